// File: rtl/rpn_stack_controller.sv
// RPN operand stack sequencer feeding NOS/TOS to the ALU and writing back its result.
// Optional RPN_ERRSTICKY_EN: ERROR latches until the next accepted command.
module rpn_stack_controller #(
    parameter int DEPTH   = 4,
    parameter int WIDTH   = 16,
    parameter int ALU_LAT = 1
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    input  logic                         i_push,
    input  logic                         i_exec,
    input  logic                         i_drop,
    input  logic [7:0]                   i_operand,
    input  logic [2:0]                   i_opcode,
    input  logic [WIDTH-1:0]             i_alu_result,
    output logic [WIDTH-1:0]             o_alu_a,
    output logic [WIDTH-1:0]             o_alu_b,
    output logic [2:0]                   o_alu_op,
    output logic [WIDTH-1:0]             o_tos,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_busy,
    output logic                         o_error
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] C_TWO   = CW'(2);
    localparam logic [2:0]    C_LAT   = 3'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE
    } state_t;

    state_t               r_state;
    state_t               w_state_n;
    logic [WIDTH-1:0]     r_level   [DEPTH];
    logic [WIDTH-1:0]     w_level_n [DEPTH];
    logic [CW-1:0]        r_count;
    logic [CW-1:0]        w_count_n;
    logic [WIDTH-1:0]     r_tos;
    logic [WIDTH-1:0]     w_tos_n;
    logic [WIDTH-1:0]     r_alu_a;
    logic [WIDTH-1:0]     r_alu_b;
    logic [WIDTH-1:0]     w_nos;
    logic [2:0]           r_alu_op;
    logic [2:0]           r_lat_cnt;
    logic [2:0]           w_lat_cnt_n;
    logic                 r_error;
    logic                 w_load;
    logic                 w_err_set;
    logic                 w_accept;

    always_comb begin
        w_nos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == r_count - C_TWO) w_nos = r_level[i];
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_lat_cnt_n = r_lat_cnt;
        w_count_n   = r_count;
        w_level_n   = r_level;
        w_load      = 1'b0;
        w_err_set   = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_exec) begin
                    if (r_count >= C_TWO) begin
                        w_load      = 1'b1;
                        w_accept    = 1'b1;
                        w_lat_cnt_n = C_LAT;
                        w_state_n   = S_LOAD;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end else if (i_push) begin
                    if (r_count < C_DEPTH) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (CW'(i) == r_count)
                                w_level_n[i] = {{(WIDTH-8){1'b0}}, i_operand};
                        end
                        w_count_n = r_count + C_ONE;
                        w_accept  = 1'b1;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end else if (i_drop) begin
                    if (r_count != '0) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (CW'(i) == r_count - C_ONE) w_level_n[i] = '0;
                        end
                        w_count_n = r_count - C_ONE;
                        w_accept  = 1'b1;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (r_lat_cnt == '0) w_state_n = S_WRITE;
                else                 w_lat_cnt_n = r_lat_cnt - 3'd1;
            end
            S_WRITE: begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == r_count - C_TWO) w_level_n[i] = i_alu_result;
                    if (CW'(i) == r_count - C_ONE) w_level_n[i] = '0;
                end
                w_count_n = r_count - C_ONE;
                w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // TOS is registered, so derive it from the next-state stack image
    always_comb begin
        w_tos_n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i + 1) == w_count_n) w_tos_n = w_level_n[i];
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_level   <= '{default: '0};
            r_count   <= '0;
            r_tos     <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_lat_cnt <= '0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_level   <= w_level_n;
            r_count   <= w_count_n;
            r_tos     <= w_tos_n;
            r_lat_cnt <= w_lat_cnt_n;
            if (w_load) begin
                r_alu_a  <= w_nos;
                r_alu_b  <= r_tos;
                r_alu_op <= i_opcode;
            end
`ifdef RPN_ERRSTICKY_EN
            if (w_err_set)     r_error <= 1'b1;
            else if (w_accept) r_error <= 1'b0;
`else
            r_error <= w_err_set;
`endif
        end
    end

    assign o_alu_a  = r_alu_a;
    assign o_alu_b  = r_alu_b;
    assign o_alu_op = r_alu_op;
    assign o_tos    = r_tos;
    assign o_count  = r_count;
    assign o_busy   = (r_state != S_IDLE);
    assign o_error  = r_error;

endmodule
